// File: rtl/cordic_angle_prep_if.sv
// Handshake bundle between the angle source, the angle pre-processor and the CORDIC side.
// The master drives the request and the result acceptance; the slave answers.
interface cordic_angle_prep_if;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] deg_in;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        angle_out;
  logic               flip;
  logic [1:0]         quadrant;

  modport master (
    output in_valid, deg_in, out_ready,
    input  in_ready, out_valid, angle_out, flip, quadrant
  );

  modport slave (
    input  in_valid, deg_in, out_ready,
    output in_ready, out_valid, angle_out, flip, quadrant
  );
endinterface

// File: rtl/cordic_angle_prep.sv
// Reduces an integer degree angle modulo 360, folds it into [-90, 90] and scales it
// to a Q2.30 radian word; flip tells downstream to negate the CORDIC cos/sin pair.
module cordic_angle_prep (
  input  logic               clk,
  input  logic               reset,
  cordic_angle_prep_if.slave bus
);
  localparam logic [31:0] K = 32'h011DF46A;

  typedef enum logic [2:0] {IDLE, REDUCE, FOLD, SCALE, DONE} stateT;

  stateT              stateReg;
  logic signed [16:0] rReg;
  logic [6:0]         aMagReg;
  logic               aNegReg;
  logic [2:0]         bitCntReg;
  logic [31:0]        accReg;
  logic [31:0]        angleReg;
  logic               flipReg;
  logic [1:0]         quadReg;
  logic               inReadyReg;
  logic               outValidReg;

  logic [8:0]         rMod;
  logic signed [9:0]  rSigned;
  logic signed [9:0]  foldA;
  logic signed [9:0]  foldNeg;
  logic               foldFlip;
  logic [1:0]         foldQuad;
  logic [6:0]         foldMag;
  logic [31:0]        partial;
  logic [31:0]        accSum;

  // Fold decision; rReg is already in 0..359 whenever the state is FOLD.
  always_comb begin
    rMod     = rReg[8:0];
    rSigned  = signed'({1'b0, rMod});
    foldA    = rSigned;
    foldFlip = 1'b0;
    if (rMod > 9'd90 && rMod < 9'd270) begin
      foldA    = rSigned - 10'sd180;
      foldFlip = 1'b1;
    end else if (rMod >= 9'd270) begin
      foldA = rSigned - 10'sd360;
    end
    foldNeg = -foldA;
    foldMag = foldA[9] ? foldNeg[6:0] : foldA[6:0];

    if (rMod >= 9'd270)      foldQuad = 2'd3;
    else if (rMod >= 9'd180) foldQuad = 2'd2;
    else if (rMod >= 9'd90)  foldQuad = 2'd1;
    else                     foldQuad = 2'd0;
  end

  // One multiplier bit per cycle, LSB first; 90*K stays below 2^31.
  always_comb begin
    partial = aMagReg[bitCntReg] ? (K << bitCntReg) : 32'd0;
    accSum  = accReg + partial;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateReg    <= IDLE;
      rReg        <= '0;
      aMagReg     <= '0;
      aNegReg     <= 1'b0;
      bitCntReg   <= '0;
      accReg      <= '0;
      angleReg    <= '0;
      flipReg     <= 1'b0;
      quadReg     <= '0;
      inReadyReg  <= 1'b1;
      outValidReg <= 1'b0;
    end else begin
      case (stateReg)
        IDLE: begin
          if (bus.in_valid && inReadyReg) begin
            rReg       <= {bus.deg_in[15], bus.deg_in};
            accReg     <= '0;
            bitCntReg  <= '0;
            inReadyReg <= 1'b0;
            stateReg   <= REDUCE;
          end
        end
        REDUCE: begin
          if (rReg >= 17'sd360)
            rReg <= rReg - 17'sd360;
          else if (rReg < 17'sd0)
            rReg <= rReg + 17'sd360;
          else
            stateReg <= FOLD;
        end
        FOLD: begin
          quadReg  <= foldQuad;
          flipReg  <= foldFlip;
          aNegReg  <= foldA[9];
          aMagReg  <= foldMag;
          stateReg <= SCALE;
        end
        SCALE: begin
          accReg    <= accSum;
          bitCntReg <= bitCntReg + 3'd1;
          if (bitCntReg == 3'd6) begin
            angleReg    <= aNegReg ? (~accSum + 32'd1) : accSum;
            outValidReg <= 1'b1;
            stateReg    <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            outValidReg <= 1'b0;
            inReadyReg  <= 1'b1;
            stateReg    <= IDLE;
          end
        end
        default: stateReg <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = inReadyReg;
  assign bus.out_valid = outValidReg;
  assign bus.angle_out = angleReg;
  assign bus.flip      = flipReg;
  assign bus.quadrant  = quadReg;
endmodule
